sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Memory-side counterpart of the address-translation stage.
- Consumes the translated physical address, the memory operation code and the store data.
- Runs the timed chip-enable / output-enable / write-enable sequence on the external asynchronous 32-bit SRAM, and returns the raw read word to the translation stage's load-data input.
- Holds the pipeline with a stall while an access is in flight.

Parameters:
READ_CYCLES, 2, cycles the output enable is held low before read data is sampled (1..15)
WE_CYCLES, 1, cycles the write enable pulse stays low (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
physicalAddr_i  input  32  byte address from the translation stage; bits [21:2] are used
memOp_i  input  4  0000 none, 0001 load word, 0010 store byte, 0011 store half, 0100 store word; all other codes = none
storeData_i  input  32  store data; byte and half values are in the low bits
ramData_o  output  32  registered raw word read from the SRAM
stall_o  output  1  pipeline hold request
sram_addr_o  output  20  SRAM word address
sram_data_io  inout  32  SRAM data bus; driven only in write states, high-Z otherwise
sram_ce_n_o  output  1  chip enable, active low
sram_oe_n_o  output  1  output enable, active low
sram_we_n_o  output  1  write enable, active low
sram_be_n_o  output  4  byte enables, active low; bit i selects lane [8i+7:8i]

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE; ramData_o=0; sram_addr_o=0.
  - ce_n, oe_n and we_n all 1; be_n=4'b1111; data bus high-Z.
  - A reset mid-access aborts the access immediately and releases the bus in the same instant. There is no partial-write recovery.
- States: IDLE, READ, WSETUP, WPULSE, WHOLD, DONE. A 4-bit counter cnt times READ and WPULSE.
- IDLE:
  - On a valid op, latch addr[21:2], op and the formatted data/byte enables.
  - Load: go to READ with cnt=READ_CYCLES-1. Store: go to WSETUP. Op none: stay in IDLE.
- READ:
  - ce_n=0, oe_n=0, we_n=1, be_n=0000.
  - When cnt=0, sample sram_data_io into ramData_o and go to DONE; otherwise decrement cnt.
- WSETUP: ce_n=0, oe_n=1, we_n=1, bus driven; next state WPULSE with cnt=WE_CYCLES-1.
- WPULSE: we_n=0; when cnt=0, go to WHOLD.
- WHOLD: we_n=1; ce_n, address and data held; next state DONE.
- DONE: ce_n=1, oe_n=1, bus high-Z; next state IDLE unconditionally.
- Control timing:
  - ce_n, oe_n, we_n and be_n are registered outputs derived from the next state, so they are glitch-free.
  - Address and data are stable from WSETUP through WHOLD.
- stall_o (combinational) = (IDLE and valid op) or state in {READ, WSETUP, WPULSE, WHOLD}.
  - stall_o=0 in DONE, so the pipeline advances at the edge that ends DONE.
  - In the IDLE cycle that follows, the next op is sampled. Back-to-back ops therefore incur one idle gap cycle.
- Latency, counting from the accept edge to the first stall-free cycle:
  - load = READ_CYCLES+1 cycles.
  - store = WE_CYCLES+3 cycles.
- Store formatting:
  - SB: the byte is replicated into all 4 lanes; be_n has a single 0 at lane addr[1:0].
  - SH: the half is replicated into both halves; be_n=1100 if addr[1]=0, 0011 if addr[1]=1; addr[0] is ignored.
  - SW: be_n=0000; physicalAddr_i[1:0] is ignored.
- ramData_o holds its value until the next completed load; stores do not modify it.
- Inputs are ignored in every state except IDLE.

Test Plan:
- Reset: hold rst=0 over 3 edges, then release with memOp=0000 -> all controls 1, be_n=1111, bus Z, stall_o=0, ramData_o=0.
- SW 0xDEADBEEF at addr 0x0000_1004 (defaults) -> sram_addr_o=0x00401; we_n low for exactly 1 cycle, bracketed by one setup and one hold cycle; be_n=0000; stall_o high for 3 cycles after accept, then low in DONE.
- Load at 0x0000_1004 with the SRAM model returning 0xDEADBEEF -> oe_n low for 2 cycles; ramData_o=0xDEADBEEF in DONE; stall_o low in DONE.
- SB data 0x000000A5 at addr 0x...3 -> bus 0xA5A5A5A5, be_n=0111. SH data 0x1234 at addr 0x...2 -> bus 0x12341234, be_n=0011.
- Back-to-back SW then load with READ_CYCLES=3 and WE_CYCLES=2 -> one IDLE gap between the accesses; oe_n and we_n never low together; stall latencies are 5 and 4.
- Assert rst=0 during WPULSE -> we_n and ce_n go to 1 and the bus goes Z without waiting for an edge; state=IDLE after release.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: timed CE/OE/WE sequencer for an external asynchronous 32-bit SRAM with pipeline stall
module sram_ctrl #(
   parameter int READ_CYCLES = 2,
   parameter int WE_CYCLES   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] physicalAddr_i,
   input  logic [3:0]  memOp_i,
   input  logic [31:0] storeData_i,
   output logic [31:0] ramData_o,
   output logic        stall_o,
   output logic [19:0] sram_addr_o,
   inout  wire  [31:0] sram_data_io,
   output logic        sram_ce_n_o,
   output logic        sram_oe_n_o,
   output logic        sram_we_n_o,
   output logic [3:0]  sram_be_n_o
);
   typedef enum logic [2:0] {IDLE, READ, WSETUP, WPULSE, WHOLD, DONE} state_t;
   state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic [31:0] wdata, fmt_data;
   logic [3:0] fmt_be;
   logic is_ld, is_st, drive, unused;
   assign is_ld = memOp_i == 4'b0001;
   assign is_st = memOp_i inside {4'b0010, 4'b0011, 4'b0100};
   assign drive = state inside {WSETUP, WPULSE, WHOLD};
   assign sram_data_io = drive ? wdata : 'z;
   assign stall_o = (state == IDLE && (is_ld || is_st)) || drive || state == READ;
   assign fmt_data = memOp_i == 4'b0010 ? {4{storeData_i[7:0]}} :
                     memOp_i == 4'b0011 ? {2{storeData_i[15:0]}} : storeData_i;
   assign fmt_be = memOp_i == 4'b0010 ? ~(4'b0001 << physicalAddr_i[1:0]) :
                   memOp_i == 4'b0011 ? (physicalAddr_i[1] ? 4'b0011 : 4'b1100) : 4'b0000;
   assign unused = ^physicalAddr_i[31:22];
   // next state and access-phase timer
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      case (state)
         IDLE: begin
            if (is_ld) begin
               state_nx = READ;
               cnt_nx = 4'(READ_CYCLES - 1);
            end else if (is_st) state_nx = WSETUP;
         end
         READ: if (cnt == 4'd0) state_nx = DONE; else cnt_nx = cnt - 4'd1;
         WSETUP: begin
            state_nx = WPULSE;
            cnt_nx = 4'(WE_CYCLES - 1);
         end
         WPULSE: if (cnt == 4'd0) state_nx = WHOLD; else cnt_nx = cnt - 4'd1;
         WHOLD: state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   // state, latched access, read capture and glitch-free strobes registered from the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= 4'd0;
         ramData_o <= 32'd0;
         sram_addr_o <= 20'd0;
         wdata <= 32'd0;
         sram_ce_n_o <= 1'b1;
         sram_oe_n_o <= 1'b1;
         sram_we_n_o <= 1'b1;
         sram_be_n_o <= 4'b1111;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         if (state == IDLE && (is_ld || is_st)) begin
            sram_addr_o <= physicalAddr_i[21:2];
            wdata <= fmt_data;
         end
         if (state == READ && cnt == 4'd0) ramData_o <= sram_data_io;
         sram_ce_n_o <= state_nx inside {IDLE, DONE};
         sram_oe_n_o <= state_nx != READ;
         sram_we_n_o <= state_nx != WPULSE;
         sram_be_n_o <= state_nx == READ ? 4'b0000 :
                        state == IDLE && state_nx == WSETUP ? fmt_be :
                        state_nx inside {WSETUP, WPULSE, WHOLD} ? sram_be_n_o : 4'b1111;
      end
   end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: phase-level model check of two sram_ctrl configurations against SRAM models
module tb_sram_ctrl;
   logic clk = 0;
   logic rst = 0;
   always #5 clk = ~clk;
   logic [31:0] paddr [2], sdata [2], ramdata [2], bus [2];
   logic [3:0] op [2], be_n [2];
   logic [19:0] saddr [2];
   logic stall [2], ce_n [2], oe_n [2], we_n [2];
   tri1 [31:0] bus0, bus1;
   logic [31:0] mem [2][1024];
   logic [31:0] shadow [2][1024];
   logic inited = 0;
   int n_chk = 0, n_fail = 0;
   assign bus[0] = bus0;
   assign bus[1] = bus1;
   assign bus0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? mem[0][saddr[0][9:0]] : 32'bz;
   assign bus1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? mem[1][saddr[1][9:0]] : 32'bz;
   sram_ctrl u0 (.clk(clk), .rst(rst), .physicalAddr_i(paddr[0]), .memOp_i(op[0]), .storeData_i(sdata[0]),
      .ramData_o(ramdata[0]), .stall_o(stall[0]), .sram_addr_o(saddr[0]), .sram_data_io(bus0),
      .sram_ce_n_o(ce_n[0]), .sram_oe_n_o(oe_n[0]), .sram_we_n_o(we_n[0]), .sram_be_n_o(be_n[0]));
   sram_ctrl #(.READ_CYCLES(3), .WE_CYCLES(2)) u1 (.clk(clk), .rst(rst), .physicalAddr_i(paddr[1]),
      .memOp_i(op[1]), .storeData_i(sdata[1]), .ramData_o(ramdata[1]), .stall_o(stall[1]),
      .sram_addr_o(saddr[1]), .sram_data_io(bus1), .sram_ce_n_o(ce_n[1]), .sram_oe_n_o(oe_n[1]),
      .sram_we_n_o(we_n[1]), .sram_be_n_o(be_n[1]));
   // SRAM array: byte-lane writes on every edge that closes a cycle with CE and WE low
   always @(posedge clk) begin
      if (!inited) begin
         for (int i = 0; i < 2; i++) for (int j = 0; j < 1024; j++) mem[i][j] <= 32'd0;
         mem[0][16] <= 32'h5A5A5A5A;
      end else
         for (int i = 0; i < 2; i++)
            if (!ce_n[i] && !we_n[i])
               for (int b = 0; b < 4; b++)
                  if (!be_n[i][b]) mem[i][saddr[i][9:0]][8*b +: 8] <= bus[i][8*b +: 8];
   end
   int mk [2];
   logic mld [2];
   logic [19:0] maddr [2];
   logic [31:0] mdata [2], mrd [2];
   logic [3:0] mbe [2];
   function automatic int rc(int i); return i == 0 ? 2 : 3; endfunction
   function automatic int wc(int i); return i == 0 ? 1 : 2; endfunction
   function automatic logic valid(logic [3:0] o); return o >= 4'd1 && o <= 4'd4; endfunction
   function automatic int last(int i); return mld[i] ? rc(i) + 1 : wc(i) + 3; endfunction
   function automatic logic [35:0] fmt(logic [3:0] o, logic [31:0] a, logic [31:0] d);
      logic [3:0] be;
      logic [31:0] dat;
      be = 4'b0000;
      dat = d;
      if (o == 4'd2) begin
         be = 4'hF;
         be[a[1:0]] = 1'b0;
         dat = {24'h0, d[7:0]} * 32'h01010101;
      end else if (o == 4'd3) begin
         be = a[1] ? 4'b0011 : 4'b1100;
         dat = {d[15:0], d[15:0]};
      end
      return {be, dat};
   endfunction
   // model: phase k counts cycles since the accepting edge; memory effects land at fixed phases
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         if (!inited) begin
            for (int i = 0; i < 2; i++) for (int j = 0; j < 1024; j++) shadow[i][j] <= 32'd0;
            shadow[0][16] <= 32'h5A5A5A5A;
            inited <= 1'b1;
         end
         for (int i = 0; i < 2; i++) begin
            mk[i] <= 0;
            maddr[i] <= 20'd0;
            mrd[i] <= 32'd0;
            mld[i] <= 1'b0;
         end
      end else
         for (int i = 0; i < 2; i++) begin
            if (mk[i] == 0) begin
               if (valid(op[i])) begin
                  mk[i] <= 1;
                  mld[i] <= op[i] == 4'd1;
                  maddr[i] <= paddr[i][21:2];
                  {mbe[i], mdata[i]} <= fmt(op[i], paddr[i], sdata[i]);
               end
            end else if (mk[i] == last(i)) mk[i] <= 0;
            else begin
               mk[i] <= mk[i] + 1;
               if (mld[i] && mk[i] == rc(i)) mrd[i] <= shadow[i][maddr[i][9:0]];
               if (!mld[i] && mk[i] == wc(i) + 1)
                  for (int b = 0; b < 4; b++)
                     if (!mbe[i][b]) shadow[i][maddr[i][9:0]][8*b +: 8] <= mdata[i][8*b +: 8];
            end
         end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   int k;
   logic e_ce, e_oe, e_we, e_st;
   logic [3:0] e_be;
   logic [31:0] e_bus;
   // compare every DUT output against the model on each falling edge outside reset
   always @(negedge clk) begin
      if (rst)
         for (int i = 0; i < 2; i++) begin
            k = mk[i];
            e_ce = 1; e_oe = 1; e_we = 1; e_be = 4'hF; e_bus = 32'hFFFFFFFF;
            e_st = k != 0 || valid(op[i]);
            if (k != 0 && mld[i]) begin
               if (k <= rc(i)) begin
                  e_ce = 0; e_oe = 0; e_be = 4'h0; e_bus = shadow[i][maddr[i][9:0]];
               end else e_st = 0;
            end else if (k != 0) begin
               if (k <= wc(i) + 2) begin
                  e_ce = 0; e_be = mbe[i]; e_bus = mdata[i]; e_we = !(k >= 2 && k <= wc(i) + 1);
               end else e_st = 0;
            end
            chk($sformatf("u%0d k%0d ce_n", i, k), 32'(ce_n[i]), 32'(e_ce));
            chk($sformatf("u%0d k%0d oe_n", i, k), 32'(oe_n[i]), 32'(e_oe));
            chk($sformatf("u%0d k%0d we_n", i, k), 32'(we_n[i]), 32'(e_we));
            chk($sformatf("u%0d k%0d be_n", i, k), 32'(be_n[i]), 32'(e_be));
            chk($sformatf("u%0d k%0d bus", i, k), bus[i], e_bus);
            chk($sformatf("u%0d k%0d stall", i, k), 32'(stall[i]), 32'(e_st));
            chk($sformatf("u%0d k%0d addr", i, k), 32'(saddr[i]), 32'(maddr[i]));
            chk($sformatf("u%0d k%0d ramData", i, k), ramdata[i], mrd[i]);
         end
   end
   int r_gap, r_nst, r_noe, r_nwe, r_nce;
   logic [31:0] r_bus;
   logic [3:0] r_be;
   // present an op (at posedge+1), wait for acceptance, then measure the stalled access until DONE
   task automatic do_op(input int i, input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
      op[i] = o; paddr[i] = a; sdata[i] = d;
      r_gap = 0; r_nst = 0; r_noe = 0; r_nwe = 0; r_nce = 0; r_bus = 32'd0; r_be = 4'hF;
      #1;
      while (!stall[i] && r_gap < 20) begin
         r_gap++;
         @(posedge clk); #1;
      end
      while (stall[i] && r_nst < 40) begin
         r_nst++;
         if (!oe_n[i]) r_noe++;
         if (!ce_n[i]) r_nce++;
         if (!we_n[i]) begin
            r_nwe++; r_bus = bus[i]; r_be = be_n[i];
         end
         @(posedge clk); #1;
      end
      op[i] = 4'd0;
   endtask
   initial begin
      for (int i = 0; i < 2; i++) begin
         op[i] = 4'd0; paddr[i] = 32'd0; sdata[i] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1;
      @(negedge clk);
      chk("reset ce_n", 32'(ce_n[0]), 32'd1);
      chk("reset oe_n", 32'(oe_n[0]), 32'd1);
      chk("reset we_n", 32'(we_n[0]), 32'd1);
      chk("reset be_n", 32'(be_n[0]), 32'hF);
      chk("reset bus released", bus0, 32'hFFFFFFFF);
      chk("reset stall", 32'(stall[0]), 32'd0);
      chk("reset ramData", ramdata[0], 32'd0);
      @(posedge clk); #1;
      do_op(0, 4'd4, 32'h00001004, 32'hDEADBEEF);
      chk("sw gap", 32'(r_gap), 32'd0);
      chk("sw stall cycles", 32'(r_nst), 32'd4);
      chk("sw we_n low cycles", 32'(r_nwe), 32'd1);
      chk("sw ce_n low cycles", 32'(r_nce), 32'd3);
      chk("sw oe_n low cycles", 32'(r_noe), 32'd0);
      chk("sw be_n", 32'(r_be), 32'h0);
      chk("sw bus", r_bus, 32'hDEADBEEF);
      chk("sw addr", 32'(saddr[0]), 32'h00401);
      chk("sw stall in done", 32'(stall[0]), 32'd0);
      do_op(0, 4'd1, 32'h00001004, 32'd0);
      chk("lw stall cycles", 32'(r_nst), 32'd3);
      chk("lw oe_n low cycles", 32'(r_noe), 32'd2);
      chk("lw ramData", ramdata[0], 32'hDEADBEEF);
      chk("lw stall in done", 32'(stall[0]), 32'd0);
      do_op(0, 4'd2, 32'h00002003, 32'h000000A5);
      chk("sb bus", r_bus, 32'hA5A5A5A5);
      chk("sb be_n", 32'(r_be), 32'b0111);
      do_op(0, 4'd3, 32'h0000300A, 32'h00001234);
      chk("sh bus", r_bus, 32'h12341234);
      chk("sh be_n", 32'(r_be), 32'b0011);
      do_op(0, 4'd1, 32'h00002003, 32'd0);
      chk("lb-lane readback", ramdata[0], 32'hA5000000);
      @(posedge clk); #1;
      op[0] = 4'hF;
      #1 chk("invalid op stall", 32'(stall[0]), 32'd0);
      @(posedge clk); #1;
      chk("invalid op ce_n", 32'(ce_n[0]), 32'd1);
      op[0] = 4'd0;
      do_op(1, 4'd4, 32'h00000100, 32'hCAFEF00D);
      chk("b2b sw stall cycles", 32'(r_nst), 32'd5);
      chk("b2b sw we_n low cycles", 32'(r_nwe), 32'd2);
      do_op(1, 4'd1, 32'h00000100, 32'd0);
      chk("b2b gap", 32'(r_gap), 32'd1);
      chk("b2b lw stall cycles", 32'(r_nst), 32'd4);
      chk("b2b lw oe_n low cycles", 32'(r_noe), 32'd3);
      chk("b2b lw ramData", ramdata[1], 32'hCAFEF00D);
      @(posedge clk); #1;
      op[0] = 4'd4; paddr[0] = 32'h00000040; sdata[0] = 32'h11111111;
      @(posedge clk); #1;
      op[0] = 4'd0;
      @(posedge clk); #3;
      chk("pulse we_n low", 32'(we_n[0]), 32'd0);
      rst = 0;
      #1;
      chk("async rst we_n", 32'(we_n[0]), 32'd1);
      chk("async rst ce_n", 32'(ce_n[0]), 32'd1);
      chk("async rst be_n", 32'(be_n[0]), 32'hF);
      chk("async rst bus released", bus0, 32'hFFFFFFFF);
      chk("async rst stall", 32'(stall[0]), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1;
      chk("post rst addr", 32'(saddr[0]), 32'd0);
      chk("post rst ramData", ramdata[0], 32'd0);
      do_op(0, 4'd1, 32'h00000040, 32'd0);
      chk("post rst lw stall cycles", 32'(r_nst), 32'd3);
      chk("aborted store left word intact", ramdata[0], 32'h5A5A5A5A);
      repeat (3) @(posedge clk);
      #1 $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
